// File: rtl/ofdm_pkg.sv
// ofdm_pkg: OFDM modem defaults shared by CP insertion and removal, plus the CP removal state type
package ofdm_pkg;
  localparam int DEF_DATA_W  = 20;
  localparam int DEF_FFT_LEN = 64;
  localparam int DEF_CP_LEN  = 16;
  typedef enum logic [1:0] {IDLE, CP, DATA} cp_state_t;
endpackage

// File: rtl/cp_symbol_counter.sv
// cp_symbol_counter: counts accepted samples within a symbol, with sync clear/restart and terminal flags
module cp_symbol_counter #(
  parameter int FFT_LEN = 64,
  parameter int CP_LEN  = 16,
  parameter int CNT_W   = $clog2(CP_LEN + FFT_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             clr,
  input  logic             restart,
  output logic [CNT_W-1:0] cnt,
  output logic             tc_cp,
  output logic             tc_end
);
  // restart loads 1 because the in_sop sample that triggers it is already k=0
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (restart) cnt <= CNT_W'(1);
    else if (step) cnt <= cnt + CNT_W'(1);
  assign tc_cp  = cnt == CNT_W'(CP_LEN - 1);
  assign tc_end = cnt == CNT_W'(CP_LEN + FFT_LEN - 1);
endmodule

// File: rtl/cp_remove.sv
// cp_remove: drops the cyclic prefix of each received OFDM symbol and forwards FFT_LEN indexed samples.
// Define CP_REMOVE_ERR_EN to add the sop_err resync pulse output.
module cp_remove import ofdm_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int FFT_LEN = DEF_FFT_LEN,
  parameter int CP_LEN  = DEF_CP_LEN,
  parameter int IDX_W   = $clog2(FFT_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  input  logic              in_valid,
  input  logic              in_sop,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_q,
  output logic              out_valid,
  output logic              sop_out,
  output logic              eop_out,
  output logic [IDX_W-1:0]  out_idx
`ifdef CP_REMOVE_ERR_EN
  ,
  output logic              sop_err
`endif
);
  localparam int CNT_W = $clog2(CP_LEN + FFT_LEN);
  cp_state_t state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic acc, tc_cp, tc_end, step, clr, restart, fwd;
  assign acc = en && in_valid;
  assign idx = IDX_W'(cnt - CNT_W'(CP_LEN));
  cp_symbol_counter #(.FFT_LEN(FFT_LEN), .CP_LEN(CP_LEN), .CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .step(step), .clr(clr), .restart(restart),
    .cnt(cnt), .tc_cp(tc_cp), .tc_end(tc_end)
  );
  // an accepted in_sop restarts the symbol from any state, so it is tested first
  always_comb begin
    next_state = state;
    step = 1'b0;
    clr = 1'b0;
    restart = 1'b0;
    fwd = 1'b0;
    if (acc && in_sop) begin
      restart = 1'b1;
      next_state = (CP_LEN == 1) ? DATA : CP;
    end else if (acc && state == CP) begin
      step = 1'b1;
      next_state = tc_cp ? DATA : CP;
    end else if (acc && state == DATA) begin
      fwd = 1'b1;
      step = !tc_end;
      clr = tc_end;
      next_state = tc_end ? IDLE : DATA;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      out_i <= '0;
      out_q <= '0;
      out_idx <= '0;
      out_valid <= 1'b0;
      sop_out <= 1'b0;
      eop_out <= 1'b0;
    end else begin
      state <= next_state;
      out_valid <= fwd;
      sop_out <= fwd && idx == '0;
      eop_out <= fwd && tc_end;
      if (fwd) begin
        out_i <= in_i;
        out_q <= in_q;
        out_idx <= idx;
      end
    end
`ifdef CP_REMOVE_ERR_EN
  always_ff @(posedge clk)
    if (rst) sop_err <= 1'b0;
    else sop_err <= acc && in_sop && state != IDLE;
`endif
endmodule

// File: tb/tb_cp_remove.sv
// tb_cp_remove: directed scenarios plus random traffic against a sample-index reference model
module tb_cp_remove;
  import ofdm_pkg::*;
  localparam int DW = DEF_DATA_W;
  localparam int N  = DEF_FFT_LEN;
  localparam int C  = DEF_CP_LEN;
  localparam int IW = $clog2(N);
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, in_valid = 1'b0, in_sop = 1'b0;
  logic [DW-1:0] in_i = '0, in_q = '0;
  logic [DW-1:0] out_i, out_q;
  logic [IW-1:0] out_idx;
  logic out_valid, sop_out, eop_out;
`ifdef CP_REMOVE_ERR_EN
  logic sop_err;
`endif
  always #5 clk = ~clk;
  cp_remove dut (
    .clk(clk), .rst(rst), .en(en), .in_i(in_i), .in_q(in_q),
    .in_valid(in_valid), .in_sop(in_sop), .out_i(out_i), .out_q(out_q),
    .out_valid(out_valid), .sop_out(sop_out), .eop_out(eop_out), .out_idx(out_idx)
`ifdef CP_REMOVE_ERR_EN
    , .sop_err(sop_err)
`endif
  );
  int n_cmp = 0, n_err = 0, n_out = 0, n_eop = 0, n_serr = 0;
  int k = -1;
  logic [DW-1:0] e_i = '0, e_q = '0;
  logic [IW-1:0] e_idx = '0;
  logic e_v = 1'b0, e_sop = 1'b0, e_eop = 1'b0, e_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // k is the index of the last accepted sample in the current symbol, -1 when waiting for sop
  task automatic tick();
    e_v = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_err = 1'b0;
    if (rst) begin
      k = -1; e_i = '0; e_q = '0; e_idx = '0;
    end else if (en && in_valid) begin
      if (in_sop) begin
        e_err = k >= 0;
        k = 0;
      end else if (k >= 0) k++;
      if (k >= C) begin
        e_v = 1'b1; e_i = in_i; e_q = in_q; e_idx = IW'(k - C);
        e_sop = k == C;
        e_eop = k == C + N - 1;
        if (e_eop) k = -1;
      end
    end
    @(posedge clk);
    #1;
    check("valid", 32'(out_valid), 32'(e_v));
    check("sop", 32'(sop_out), 32'(e_sop));
    check("eop", 32'(eop_out), 32'(e_eop));
    check("out_i", 32'(out_i), 32'(e_i));
    check("out_q", 32'(out_q), 32'(e_q));
    check("idx", 32'(out_idx), 32'(e_idx));
`ifdef CP_REMOVE_ERR_EN
    check("sop_err", 32'(sop_err), 32'(e_err));
    if (sop_err) n_serr++;
`endif
    if (out_valid) n_out++;
    if (eop_out) n_eop++;
  endtask

  task automatic put(input logic v, input logic s, input int val);
    in_valid = v; in_sop = s; in_i = DW'(val); in_q = DW'(-val);
    tick();
  endtask

  task automatic sym(input int from, input int to, input logic gaps);
    for (int j = from; j <= to; j++) begin
      if (gaps) put(1'b0, 1'b0, $urandom);
      put(1'b1, j == 0, j);
    end
  endtask

  task automatic clear_counts();
    n_out = 0; n_eop = 0; n_serr = 0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    clear_counts();
    sym(0, C + N - 1, 1'b0);
    put(1'b0, 1'b0, 0);
    check("single_cnt", n_out, N);
    check("single_eop", n_eop, 1);
    clear_counts();
    for (int s = 0; s < 3; s++) sym(0, C + N - 1, 1'b0);
    put(1'b0, 1'b0, 0);
    check("b2b_cnt", n_out, 3 * N);
    clear_counts();
    sym(0, C + N - 1, 1'b1);
    put(1'b0, 1'b0, 0);
    check("gap_cnt", n_out, N);
    clear_counts();
    sym(0, 39, 1'b0);
    sym(0, C + N - 1, 1'b0);
    put(1'b0, 1'b0, 0);
    check("resync_cnt", n_out, 24 + N);
    check("resync_eop", n_eop, 1);
`ifdef CP_REMOVE_ERR_EN
    check("resync_err", n_serr, 1);
`endif
    clear_counts();
    for (int j = 0; j < 10; j++) put(1'b1, 1'b0, 1000 + j);
    sym(0, C + N - 1, 1'b0);
    put(1'b0, 1'b0, 0);
    check("garbage_cnt", n_out, N);
    sym(0, C + 30, 1'b0);
    check("en_at30", 32'(out_idx), 32'd30);
    en = 1'b0;
    for (int j = 0; j < 5; j++) put(1'b1, 1'b0, C + 31);
    check("en_hold_idx", 32'(out_idx), 32'd30);
    en = 1'b1;
    put(1'b1, 1'b0, C + 31);
    check("resume_idx", 32'(out_idx), 32'd31);
    sym(C + 32, C + 50, 1'b0);
    rst = 1'b1;
    put(1'b1, 1'b0, C + 51);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_i", 32'(out_i), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      rst = ($urandom % 700) == 0;
      en = ($urandom % 10) != 0;
      put(($urandom % 4) != 0, ($urandom % 150) == 0, $urandom);
    end
    rst = 1'b0; en = 1'b1;
    sym(0, C + N - 1, 1'b0);
    put(1'b0, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
